// File: rtl/clk_div_sequencer.sv
// Ramps the clock divider's N input toward a requested value one legal step at a time.
// Each step is held for SETTLE+1 cycles so the divider's synchronizer sees a settled value.
module clk_div_sequencer #(
  parameter int unsigned SIZE      = 3,
  parameter int unsigned SETTLE    = 24,
  parameter int unsigned DEFAULT_N = 2
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SIZE-1:0] req_n,
  input  logic            err_clr,
  output logic [SIZE-1:0] div_n,
  output logic            busy,
  output logic            done,
  output logic            coerce_err
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SIZE-1:0] DEF_N = SIZE'(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   div_q, div_d;
  logic [SIZE-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [SIZE-1:0]   req_tgt;
  logic [SIZE-1:0]   next_n;
  logic              coerce;

  // N=1 stops the divider output, so a request of 1 is mapped to pass-through.
  assign coerce  = (req_n == SIZE'(1));
  assign req_tgt = coerce ? '0 : req_n;

  // Next legal value toward target; 0 and 2 are adjacent.
  always_comb begin
    next_n = div_q;
    if (target_q > div_q) begin
      next_n = (div_q == '0) ? SIZE'(2) : div_q + SIZE'(1);
    end else if (target_q < div_q) begin
      next_n = (div_q == SIZE'(2)) ? '0 : div_q - SIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= IDLE;
      div_q    <= DEF_N;
      target_q <= DEF_N;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d = req_tgt;
          if (coerce) begin
            err_d = 1'b1;
          end
          if (req_tgt != div_q) begin
            state_d = STEP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STEP: begin
        div_d   = next_n;
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (div_q == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = STEP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign req_ready  = (state_q == IDLE);
  assign div_n      = div_q;
  assign done       = done_q;
  assign coerce_err = err_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer: ramp timing, coercion, ignored requests and reset abort.
module tb_clk_div_sequencer;

  logic       clk;
  logic       resetb;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_n;
  logic       err_clr;
  logic [2:0] div_n;
  logic       busy;
  logic       done;
  logic       coerce_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] dv [0:159];
  logic       dn [0:159];
  logic       bs [0:159];
  logic       ce [0:159];

  clk_div_sequencer #(.SIZE(3), .SETTLE(24), .DEFAULT_N(2)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_n      (req_n),
    .err_clr    (err_clr),
    .div_n      (div_n),
    .busy       (busy),
    .done       (done),
    .coerce_err (coerce_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer n at edge E0, then record outputs after edges E0+0 .. E0+len-1.
  // While t+1 < hold, req_valid stays high with a changing req_n.
  task automatic run_req(input logic [2:0] n, input int len, input int hold);
    @(negedge clk);
    req_n     = n;
    req_valid = 1'b1;
    @(posedge clk);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      dv[t] = div_n;
      dn[t] = done;
      bs[t] = busy;
      ce[t] = coerce_err;
      if (t + 1 >= hold) req_valid = 1'b0;
      else               req_n = 3'(t * 3 + 1);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; req_valid = 1'b0; req_n = 3'd0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetb = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (div_n !== 3'd2)     begin errors++; $display("FAIL reset_div_n got=%0d exp=2", div_n); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (coerce_err !== 1'b0) begin errors++; $display("FAIL reset_coerce_err got=%b exp=0", coerce_err); end
  endtask

  task automatic test_ramp_up();
    int pulses;
    run_req(3'd5, 80, 1);
    checks++; if (dv[0] !== 3'd2)  begin errors++; $display("FAIL up_div_e0 got=%0d exp=2", dv[0]); end
    checks++; if (dv[1] !== 3'd3)  begin errors++; $display("FAIL up_div_e1 got=%0d exp=3", dv[1]); end
    checks++; if (dv[25] !== 3'd3) begin errors++; $display("FAIL up_div_e25 got=%0d exp=3", dv[25]); end
    checks++; if (dv[26] !== 3'd4) begin errors++; $display("FAIL up_div_e26 got=%0d exp=4", dv[26]); end
    checks++; if (dv[50] !== 3'd4) begin errors++; $display("FAIL up_div_e50 got=%0d exp=4", dv[50]); end
    checks++; if (dv[51] !== 3'd5) begin errors++; $display("FAIL up_div_e51 got=%0d exp=5", dv[51]); end
    checks++; if (dn[74] !== 1'b0) begin errors++; $display("FAIL up_done_e74 got=%b exp=0", dn[74]); end
    checks++; if (dn[75] !== 1'b1) begin errors++; $display("FAIL up_done_e75 got=%b exp=1", dn[75]); end
    checks++; if (bs[74] !== 1'b1) begin errors++; $display("FAIL up_busy_e74 got=%b exp=1", bs[74]); end
    checks++; if (bs[75] !== 1'b0) begin errors++; $display("FAIL up_busy_e75 got=%b exp=0", bs[75]); end
    pulses = 0;
    for (int t = 0; t < 80; t++) if (dn[t] === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_done_count got=%0d exp=1", pulses); end
  endtask

  task automatic test_ramp_down();
    int ones;
    run_req(3'd3, 60, 1);
    checks++; if (dv[26] !== 3'd3) begin errors++; $display("FAIL dn53_div_e26 got=%0d exp=3", dv[26]); end
    checks++; if (dn[50] !== 1'b1) begin errors++; $display("FAIL dn53_done_e50 got=%b exp=1", dn[50]); end
    run_req(3'd0, 60, 1);
    checks++; if (dv[1] !== 3'd2)  begin errors++; $display("FAIL dn30_div_e1 got=%0d exp=2", dv[1]); end
    checks++; if (dv[25] !== 3'd2) begin errors++; $display("FAIL dn30_div_e25 got=%0d exp=2", dv[25]); end
    checks++; if (dv[26] !== 3'd0) begin errors++; $display("FAIL dn30_div_e26 got=%0d exp=0", dv[26]); end
    checks++; if (dn[49] !== 1'b0) begin errors++; $display("FAIL dn30_done_e49 got=%b exp=0", dn[49]); end
    checks++; if (dn[50] !== 1'b1) begin errors++; $display("FAIL dn30_done_e50 got=%b exp=1", dn[50]); end
    ones = 0;
    for (int t = 0; t < 60; t++) if (dv[t] === 3'd1) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL dn30_saw_one got=%0d exp=0", ones); end
  endtask

  task automatic test_coerce();
    run_req(3'd1, 4, 1);
    checks++; if (ce[0] !== 1'b1) begin errors++; $display("FAIL coerce_set got=%b exp=1", ce[0]); end
    checks++; if (dn[0] !== 1'b1) begin errors++; $display("FAIL coerce_done got=%b exp=1", dn[0]); end
    checks++; if (dv[3] !== 3'd0) begin errors++; $display("FAIL coerce_div got=%0d exp=0", dv[3]); end
    checks++; if (ce[3] !== 1'b1) begin errors++; $display("FAIL coerce_sticky got=%b exp=1", ce[3]); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (coerce_err !== 1'b0) begin errors++; $display("FAIL coerce_clr got=%b exp=0", coerce_err); end
    @(negedge clk); err_clr = 1'b1; req_valid = 1'b1; req_n = 3'd1;
    @(negedge clk); err_clr = 1'b0; req_valid = 1'b0;
    checks++; if (coerce_err !== 1'b1) begin errors++; $display("FAIL coerce_set_wins got=%b exp=1", coerce_err); end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    checks++; if (coerce_err !== 1'b0) begin errors++; $display("FAIL coerce_reclr got=%b exp=0", coerce_err); end
  endtask

  task automatic test_equal_and_ignore();
    run_req(3'd2, 30, 1);
    checks++; if (dn[25] !== 1'b1) begin errors++; $display("FAIL eq_setup_done got=%b exp=1", dn[25]); end
    run_req(3'd2, 4, 1);
    checks++; if (dn[0] !== 1'b1) begin errors++; $display("FAIL eq_done_e0 got=%b exp=1", dn[0]); end
    checks++; if (bs[0] !== 1'b0) begin errors++; $display("FAIL eq_busy_e0 got=%b exp=0", bs[0]); end
    checks++; if (dn[1] !== 1'b0) begin errors++; $display("FAIL eq_done_e1 got=%b exp=0", dn[1]); end
    checks++; if (dv[3] !== 3'd2) begin errors++; $display("FAIL eq_div got=%0d exp=2", dv[3]); end
    run_req(3'd4, 60, 49);
    checks++; if (dv[1] !== 3'd3)  begin errors++; $display("FAIL ign_div_e1 got=%0d exp=3", dv[1]); end
    checks++; if (dv[26] !== 3'd4) begin errors++; $display("FAIL ign_div_e26 got=%0d exp=4", dv[26]); end
    checks++; if (dn[50] !== 1'b1) begin errors++; $display("FAIL ign_done_e50 got=%b exp=1", dn[50]); end
    checks++; if (dv[59] !== 3'd4) begin errors++; $display("FAIL ign_div_end got=%0d exp=4", dv[59]); end
    checks++; if (ce[59] !== 1'b0) begin errors++; $display("FAIL ign_coerce got=%b exp=0", ce[59]); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    run_req(3'd2, 55, 1);
    checks++; if (dv[54] !== 3'd2) begin errors++; $display("FAIL abort_setup_div got=%0d exp=2", dv[54]); end
    @(negedge clk); req_valid = 1'b1; req_n = 3'd7;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    checks++; if (div_n !== 3'd4) begin errors++; $display("FAIL abort_pre_div got=%0d exp=4", div_n); end
    resetb = 1'b0;
    #1;
    checks++; if (div_n !== 3'd2)     begin errors++; $display("FAIL abort_div got=%0d exp=2", div_n); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (t == 2) resetb = 1'b1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_done_count got=%0d exp=0", pulses); end
    run_req(3'd7, 130, 1);
    checks++; if (dv[1] !== 3'd3)   begin errors++; $display("FAIL post_div_e1 got=%0d exp=3", dv[1]); end
    checks++; if (dv[101] !== 3'd7) begin errors++; $display("FAIL post_div_e101 got=%0d exp=7", dv[101]); end
    checks++; if (dn[124] !== 1'b0) begin errors++; $display("FAIL post_done_e124 got=%b exp=0", dn[124]); end
    checks++; if (dn[125] !== 1'b1) begin errors++; $display("FAIL post_done_e125 got=%b exp=1", dn[125]); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_coerce();
    test_equal_and_ignore();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
